pio_edge_capture_in: RTL

- Avalon-MM slave parallel input port: the read-side counterpart of the LED output PIO.
- Samples an external WIDTH-bit input bus (push-buttons, frequency-meter status lines) through a synchronizer.
- Detects per-bit edges and latches them in a sticky edge-capture register.
- Raises a level interrupt to the Nios processor under a software mask.

---
 rtl/pio_edge_capture_in.sv | 89 ++++++++
 1 files changed

// File: rtl/pio_edge_capture_in.sv
// Avalon-MM parallel input port: synchronized inputs, sticky per-bit edge capture
// with write-1-to-clear, and a masked level interrupt.
module pio_edge_capture_in #(
  parameter int              WIDTH         = 8,
  parameter int              EDGE_TYPE     = 0,
  parameter int              SYNC_STAGES   = 2,
  parameter logic [WIDTH-1:0] RESET_IRQMASK = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int             CW        = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0]  WARM_DONE = CW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] d_sync;
  logic [WIDTH-1:0] d_prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] capture_next;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] clr;
  logic [CW-1:0]    warm_cnt;
  logic             warm_done;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;
  assign d_sync       = sync_q[SYNC_STAGES-1];
  assign warm_done    = (warm_cnt == WARM_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Edges are suppressed until the synchronizer and d_prev hold real input data.
  always_comb begin
    edge_det = '0;
    if (warm_done) begin
      case (EDGE_TYPE)
        0:       edge_det = d_sync & ~d_prev;
        1:       edge_det = ~d_sync & d_prev;
        default: edge_det = d_sync ^ d_prev;
      endcase
    end
    wr_en        = chipselect & ~write_n;
    clr          = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    capture_next = edge_det | (edge_capture & ~clr);
    mask_next    = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irq_mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_prev       <= '0;
      warm_cnt     <= '0;
      edge_capture <= '0;
      irq_mask     <= RESET_IRQMASK;
      irq          <= 1'b0;
      readdata     <= '0;
    end else begin
      d_prev       <= d_sync;
      if (!warm_done) warm_cnt <= warm_cnt + CW'(1);
      edge_capture <= capture_next;
      irq_mask     <= mask_next;
      irq          <= |(capture_next & mask_next);
      case (address)
        2'd0:    readdata <= 32'(d_sync);
        2'd2:    readdata <= 32'(irq_mask);
        2'd3:    readdata <= 32'(edge_capture);
        default: readdata <= '0;
      endcase
    end
  end

endmodule
